// File: rtl/sync_crossbar_pkg.sv
// Shared crossbar types and default sizes for the router datapath.
// The top module takes its default parameters from here.
package sync_crossbar_pkg;

  localparam int XBAR_ARITY     = 5;
  localparam int XBAR_DATA_W    = 32;
  localparam int XBAR_OUT_DEPTH = 2;

  typedef logic [XBAR_DATA_W-1:0] flit_t;

  // Row i, column j set means input i routes to output j.
  typedef logic [XBAR_ARITY-1:0][XBAR_ARITY-1:0] xbar_sel_t;

endpackage

// File: rtl/xbar_out_fifo.sv
// Per-output flit queue with a registered head.
// There is no pass-through when the queue is full, and the head holds its last value once the queue is empty.
module xbar_out_fifo #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;

  assign full        = (count == CNT_W'(OUT_DEPTH));
  assign valid       = (count != '0);
  assign push        = wr_en && !full;
  assign pop         = rd_en && valid;
  assign rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // The head register takes the incoming flit only when it lands in an otherwise empty queue.
  always_ff @(posedge clk) begin
    if (preset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (count_next != '0)
        rd_data <= (push && ((count - CNT_W'(pop)) == '0)) ? wr_data : mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/sync_crossbar.sv
// Clocked ARITY x ARITY crossbar with per-port valid/ready, per-output FIFOs and atomic multicast.
// Column conflicts are resolved in favour of the lowest-index input.
module sync_crossbar
  import sync_crossbar_pkg::*;
#(
  parameter int ARITY     = XBAR_ARITY,
  parameter int DATA_W    = XBAR_DATA_W,
  parameter int OUT_DEPTH = XBAR_OUT_DEPTH
) (
  input  logic                    clk,
  input  logic                    preset,
  input  logic [ARITY*ARITY-1:0]  switch_sel,
  input  logic [ARITY-1:0]        in_valid,
  input  logic [ARITY*DATA_W-1:0] in_data,
  output logic [ARITY-1:0]        in_ready,
  output logic [ARITY-1:0]        out_valid,
  output logic [ARITY*DATA_W-1:0] out_data,
  input  logic [ARITY-1:0]        out_ready,
  output logic [ARITY-1:0]        conflict
);

  logic [ARITY-1:0]  sel_row    [ARITY];
  logic [ARITY-1:0]  win_row    [ARITY];
  logic [ARITY-1:0]  conflict_d;
  logic [ARITY-1:0]  fifo_full;
  logic [ARITY-1:0]  fifo_wr;
  logic [DATA_W-1:0] fifo_wdata [ARITY];
  logic [ARITY-1:0]  fire;

  always_comb begin
    for (int i = 0; i < ARITY; i++)
      sel_row[i] = switch_sel[i*ARITY +: ARITY];
  end

  // Per column, the first valid contender wins and any later one marks a conflict.
  always_comb begin
    logic taken;
    conflict_d = '0;
    for (int i = 0; i < ARITY; i++) win_row[i] = '0;
    for (int j = 0; j < ARITY; j++) begin
      taken = 1'b0;
      for (int i = 0; i < ARITY; i++) begin
        if (in_valid[i] && sel_row[i][j]) begin
          if (taken) conflict_d[j] = 1'b1;
          else       win_row[i][j] = 1'b1;
          taken = 1'b1;
        end
      end
    end
  end

  // Atomic join: every selected column must be won and have space, otherwise nothing moves.
  always_comb begin
    for (int i = 0; i < ARITY; i++)
      in_ready[i] = !preset && (|sel_row[i]) &&
                    ((sel_row[i] & ~(win_row[i] & ~fifo_full)) == '0);
  end

  assign fire = in_valid & in_ready;

  always_comb begin
    fifo_wr = '0;
    for (int j = 0; j < ARITY; j++) fifo_wdata[j] = '0;
    for (int j = 0; j < ARITY; j++) begin
      for (int i = 0; i < ARITY; i++) begin
        if (fire[i] && sel_row[i][j]) begin
          fifo_wr[j]    = 1'b1;
          fifo_wdata[j] = in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (preset) conflict <= '0;
    else        conflict <= conflict_d;
  end

  for (genvar j = 0; j < ARITY; j++) begin : g_out
    xbar_out_fifo #(
      .DATA_W    (DATA_W),
      .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .preset  (preset),
      .wr_en   (fifo_wr[j]),
      .wr_data (fifo_wdata[j]),
      .full    (fifo_full[j]),
      .rd_en   (out_ready[j]),
      .rd_data (out_data[j*DATA_W +: DATA_W]),
      .valid   (out_valid[j])
    );
  end

endmodule

// File: tb/tb_sync_crossbar.sv
// Self-checking bench for sync_crossbar: directed scenarios followed by random traffic.
// A queue-per-output reference model supplies every expected value.
module tb_sync_crossbar;
  import sync_crossbar_pkg::*;

  localparam int N     = XBAR_ARITY;
  localparam int W     = XBAR_DATA_W;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           preset;
  logic [N*N-1:0] switch_sel;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_ready;
  logic [N-1:0]   conflict;

  int checkCount = 0;
  int failCount  = 0;

  flit_t        modelQ [N][$];
  flit_t        lastHead [N];
  logic [N-1:0] expConflict;
  logic [N-1:0] sampledReady;
  logic [N-1:0] firedMask;

  xbar_sel_t    sel;
  logic [N*W-1:0] data;
  logic [N-1:0] orr;
  logic [2:0]   mcReady;
  int           k;
  int           budget;
  int           tries;

  always #5 clk = ~clk;

  sync_crossbar #(.ARITY(N), .DATA_W(W), .OUT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .preset     (preset),
    .switch_sel (switch_sel),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .conflict   (conflict)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input xbar_sel_t s, input logic [N-1:0] v, input logic [N*W-1:0] d,
                               input logic [N-1:0] r, input logic rst);
    @(negedge clk);
    switch_sel = s;
    in_valid   = v;
    in_data    = d;
    out_ready  = r;
    preset     = rst;
  endtask

  // Acceptance straight from the rules: a nonzero row, no lower-index valid input on any chosen column, and room in each.
  function automatic logic [N-1:0] modelReady();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      bit ok;
      int hits;
      ok   = 1'b1;
      hits = 0;
      for (int j = 0; j < N; j++) begin
        if (switch_sel[i*N+j]) begin
          hits++;
          if (modelQ[j].size() >= DEPTH) ok = 1'b0;
          for (int p = 0; p < i; p++)
            if (in_valid[p] && switch_sel[p*N+j]) ok = 1'b0;
        end
      end
      r[i] = !preset && in_valid[i] && ok && (hits > 0);
    end
    return r;
  endfunction

  // Compare the DUT against the model mid-cycle, then advance the model across the next rising edge.
  task automatic runCycle();
    logic [N-1:0] expValid;
    logic [N-1:0] expReady;
    int cnt;
    #1;
    expReady     = modelReady();
    sampledReady = in_ready;
    checkOutput("in_ready", in_ready, expReady);
    for (int j = 0; j < N; j++) expValid[j] = (modelQ[j].size() != 0);
    checkOutput("out_valid", out_valid, expValid);
    for (int j = 0; j < N; j++)
      checkOutput($sformatf("out_data[%0d]", j), out_data[j*W +: W],
                  (modelQ[j].size() != 0) ? modelQ[j][0] : lastHead[j]);
    checkOutput("conflict", conflict, expConflict);
    @(posedge clk);
    firedMask = in_valid & expReady;
    if (preset) begin
      for (int j = 0; j < N; j++) begin
        modelQ[j].delete();
        lastHead[j] = '0;
      end
      expConflict = '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        cnt = 0;
        for (int i = 0; i < N; i++) if (in_valid[i] && switch_sel[i*N+j]) cnt++;
        expConflict[j] = (cnt >= 2);
      end
      for (int j = 0; j < N; j++)
        if (modelQ[j].size() != 0 && out_ready[j]) lastHead[j] = modelQ[j].pop_front();
      for (int i = 0; i < N; i++)
        if (firedMask[i])
          for (int j = 0; j < N; j++)
            if (switch_sel[i*N+j]) modelQ[j].push_back(in_data[i*W +: W]);
      for (int j = 0; j < N; j++)
        if (modelQ[j].size() != 0) lastHead[j] = modelQ[j][0];
    end
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus('0, '0, '0, '1, 1'b0);
      runCycle();
    end
  endtask

  initial begin
    xbar_sel_t      rSel;
    logic [N-1:0]   rValid;
    logic [N*W-1:0] rData;
    logic [N-1:0]   row;

    preset = 1'b1; switch_sel = '0; in_valid = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    for (int j = 0; j < N; j++) lastHead[j] = '0;
    expConflict = '0;
    firedMask   = '0;

    idleCycles(1);

    $display("[TB] unicast");
    sel = '0; sel[1][3] = 1'b1;
    data = '0; data[1*W +: W] = 32'hA5A5_0001;
    applyStimulus(sel, 5'b00010, data, '1, 1'b0); runCycle();
    checkOutput("uni_ready", sampledReady[1], 1);
    #2;
    checkOutput("uni_valid", out_valid, 5'b01000);
    checkOutput("uni_data", out_data[3*W +: W], 32'hA5A5_0001);
    idleCycles(2);

    $display("[TB] multicast join");
    sel = '0; sel[0][1] = 1'b1; sel[0][4] = 1'b1;
    for (int m = 0; m < 3; m++) begin
      data = '0; data[W-1:0] = 32'h10 + m;
      applyStimulus(sel, 5'b00001, data, 5'b01101, 1'b0); runCycle();
      mcReady[m] = sampledReady[0];
    end
    checkOutput("mc_ready_seq", mcReady, 3'b011);
    #2;
    checkOutput("mc_head1", out_data[1*W +: W], 32'h10);
    checkOutput("mc_valid", out_valid, 5'b10010);
    tries = 0;
    do begin
      applyStimulus(sel, 5'b00001, data, '1, 1'b0); runCycle();
      tries++;
    end while (!sampledReady[0] && tries < 6);
    checkOutput("mc_release", sampledReady[0], 1);
    checkOutput("mc_tries", tries, 2);
    idleCycles(4);

    $display("[TB] conflict");
    sel = '0; sel[2][0] = 1'b1; sel[4][0] = 1'b1;
    data = '0; data[2*W +: W] = 32'h22; data[4*W +: W] = 32'h44;
    applyStimulus(sel, 5'b10100, data, '1, 1'b0); runCycle();
    checkOutput("cf_ready", sampledReady, 5'b00100);
    #2;
    checkOutput("cf_flag", conflict[0], 1);
    checkOutput("cf_first", out_data[W-1:0], 32'h22);
    applyStimulus(sel, 5'b10000, data, '1, 1'b0); runCycle();
    checkOutput("cf_ready2", sampledReady, 5'b10000);
    #2;
    checkOutput("cf_second", out_data[W-1:0], 32'h44);
    checkOutput("cf_flag2", conflict[0], 0);
    idleCycles(2);

    $display("[TB] backpressure and wrap");
    sel = '0; sel[3][2] = 1'b1;
    k = 0; budget = 0;
    while (k < 8 && budget < 40) begin
      data = '0; data[3*W +: W] = k;
      orr = '1; orr[2] = (budget % 2 == 0);
      applyStimulus(sel, 5'b01000, data, orr, 1'b0); runCycle();
      if (sampledReady[3]) k++;
      budget++;
    end
    checkOutput("bp_sent", k, 8);
    idleCycles(4);

    $display("[TB] reset mid-stream");
    sel = '0; sel[3][2] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      data = '0; data[3*W +: W] = 32'hB0 + m;
      applyStimulus(sel, 5'b01000, data, 5'b11011, 1'b0); runCycle();
    end
    applyStimulus(xbar_sel_t'($urandom) | xbar_sel_t'(25'h0000421), '1, {N{32'hDEAD_BEEF}}, '1, 1'b1);
    runCycle();
    checkOutput("rst_ready", sampledReady, 5'b00000);
    #2;
    checkOutput("rst_valid", out_valid, 5'b00000);
    checkOutput("rst_conflict", conflict, 5'b00000);
    data = '0; data[3*W +: W] = 32'hC0;
    applyStimulus(sel, 5'b01000, data, '1, 1'b0); runCycle();
    #2;
    checkOutput("rst_after_valid", out_valid, 5'b00100);
    checkOutput("rst_after_data", out_data[2*W +: W], 32'hC0);
    idleCycles(2);

    $display("[TB] zero row");
    data = '0; data[4*W +: W] = 32'h5A5A_5A5A;
    for (int m = 0; m < 5; m++) begin
      applyStimulus('0, 5'b10000, data, '1, 1'b0); runCycle();
      checkOutput("zero_ready", sampledReady[4], 0);
    end

    $display("[TB] random traffic");
    rSel = '0; rValid = '0; rData = '0; firedMask = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(rValid[i] && !firedMask[i])) begin
          row = '0;
          case ($urandom_range(0, 9))
            0:       row = '0;
            1, 2:    row = N'($urandom);
            default: row[$urandom_range(0, N-1)] = 1'b1;
          endcase
          rSel[i]          = row;
          rValid[i]        = ($urandom_range(0, 9) < 7);
          rData[i*W +: W]  = $urandom;
        end
      end
      applyStimulus(rSel, rValid, rData, N'($urandom) | N'($urandom),
                    ($urandom_range(0, 99) == 0));
      runCycle();
      if (preset) rValid = '0;
    end
    idleCycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
